// File: rtl/mem_bus_decoder.sv
// Routes CPU memory commands to block RAM (1-cycle read) or peripheral registers (ack/timeout).
// One read in flight; mem_cmd_ready depends only on state and drops while a peripheral access is open.
module mem_bus_decoder #(
    parameter int          RAM_ADDR_BITS  = 11,
    parameter int          PERIPH_TIMEOUT = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hdead_beef
) (
    input  logic                     clk,
    input  logic                     reset_,
    input  logic                     mem_cmd_valid,
    output logic                     mem_cmd_ready,
    input  logic                     mem_cmd_instr,
    input  logic                     mem_cmd_wr,
    input  logic [31:0]              mem_cmd_addr,
    input  logic [31:0]              mem_cmd_wdata,
    input  logic [3:0]               mem_cmd_be,
    output logic                     mem_rsp_ready,
    output logic [31:0]              mem_rsp_rdata,
    output logic                     ram_en,
    output logic [3:0]               ram_we,
    output logic [RAM_ADDR_BITS-1:0] ram_addr,
    output logic [31:0]              ram_wdata,
    input  logic [31:0]              ram_rdata,
    output logic                     periph_req,
    output logic                     periph_wr,
    output logic [31:0]              periph_addr,
    output logic [31:0]              periph_wdata,
    output logic [3:0]               periph_be,
    input  logic                     periph_ack,
    input  logic [31:0]              periph_rdata,
    output logic                     bus_err
);

    typedef enum logic [1:0] {IDLE, RAM_RD, PERIPH, P_RSP} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        p_wr_q, p_wr_d;
    logic [31:0] p_addr_q, p_addr_d;
    logic [31:0] p_wdata_q, p_wdata_d;
    logic [3:0]  p_be_q, p_be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_err_q, bus_err_d;
    logic        accept;
    logic        timeout_hit;
    logic        instr_unused;

    // Instruction fetches decode exactly like data accesses.
    assign instr_unused = mem_cmd_instr;

    assign mem_cmd_ready = (state_q == IDLE) || (state_q == RAM_RD);
    assign accept        = mem_cmd_valid && mem_cmd_ready;

    assign ram_en    = accept && !mem_cmd_addr[31];
    assign ram_we    = mem_cmd_wr ? mem_cmd_be : 4'b0000;
    assign ram_addr  = mem_cmd_addr[RAM_ADDR_BITS+1:2];
    assign ram_wdata = mem_cmd_wdata;

    assign periph_req   = (state_q == PERIPH);
    assign periph_wr    = p_wr_q;
    assign periph_addr  = p_addr_q;
    assign periph_wdata = p_wdata_q;
    assign periph_be    = p_be_q;
    assign bus_err      = bus_err_q;

    assign timeout_hit = (cnt_q == 8'(PERIPH_TIMEOUT - 1));

    always_comb begin
        mem_rsp_ready = 1'b0;
        mem_rsp_rdata = 32'h0;
        if (state_q == RAM_RD) begin
            mem_rsp_ready = 1'b1;
            mem_rsp_rdata = ram_rdata;
        end else if (state_q == P_RSP) begin
            mem_rsp_ready = 1'b1;
            mem_rsp_rdata = rdata_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        p_wr_d    = p_wr_q;
        p_addr_d  = p_addr_q;
        p_wdata_d = p_wdata_q;
        p_be_d    = p_be_q;
        rdata_d   = rdata_q;
        bus_err_d = 1'b0;
        case (state_q)
            IDLE, RAM_RD: begin
                state_d = IDLE;
                if (accept) begin
                    if (mem_cmd_addr[31]) begin
                        state_d   = PERIPH;
                        cnt_d     = 8'd0;
                        p_wr_d    = mem_cmd_wr;
                        p_addr_d  = mem_cmd_addr;
                        p_wdata_d = mem_cmd_wdata;
                        p_be_d    = mem_cmd_be;
                    end else if (!mem_cmd_wr) begin
                        state_d = RAM_RD;
                    end
                end
            end
            PERIPH: begin
                cnt_d = cnt_q + 8'd1;
                // Ack takes priority over a timeout landing in the same cycle.
                if (periph_ack) begin
                    if (p_wr_q) begin
                        state_d = IDLE;
                    end else begin
                        rdata_d = periph_rdata;
                        state_d = P_RSP;
                    end
                end else if (timeout_hit) begin
                    bus_err_d = 1'b1;
                    if (p_wr_q) begin
                        state_d = IDLE;
                    end else begin
                        rdata_d = ERR_RDATA;
                        state_d = P_RSP;
                    end
                end
            end
            P_RSP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            p_wr_q    <= 1'b0;
            p_addr_q  <= 32'h0;
            p_wdata_q <= 32'h0;
            p_be_q    <= 4'h0;
            rdata_q   <= 32'h0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            p_wr_q    <= p_wr_d;
            p_addr_q  <= p_addr_d;
            p_wdata_q <= p_wdata_d;
            p_be_q    <= p_be_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
        end
    end

endmodule

// File: doc/mem_bus_decoder.md
Name: mem_bus_decoder

Overview:
- Sits directly downstream of the CPU memory-command wrapper; consumes its single mem_cmd/mem_rsp bus.
- Decodes each command by address to an on-chip block-RAM port (fixed 1-cycle read latency) or to a peripheral register port (variable wait states, ack handshake, timeout).
- Returns read data on mem_rsp_*.
- At most one read is outstanding; writes produce no response.

Parameters:
- RAM_ADDR_BITS, 11, word-address width of the block RAM (2^11 words = 8 KB).
- PERIPH_TIMEOUT, 255, cycles in PERIPH without periph_ack before the access aborts (1..255).
- ERR_RDATA, 32'hdead_beef, read data returned on a peripheral timeout.

Ports:
- clk  in  1  system clock
- reset_  in  1  synchronous, active-low reset
- mem_cmd_valid  in  1  command valid
- mem_cmd_ready  out  1  command accepted when valid && ready
- mem_cmd_instr  in  1  instruction fetch (decode-transparent)
- mem_cmd_wr  in  1  1 = write, 0 = read
- mem_cmd_addr  in  32  byte address
- mem_cmd_wdata  in  32  write data
- mem_cmd_be  in  4  byte enables
- mem_rsp_ready  out  1  single-cycle pulse: mem_rsp_rdata valid
- mem_rsp_rdata  out  32  read data
- ram_en  out  1  RAM access strobe
- ram_we  out  4  RAM byte write enables (0 = read)
- ram_addr  out  RAM_ADDR_BITS  RAM word address = mem_cmd_addr[RAM_ADDR_BITS+1:2]
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid one cycle after ram_en with ram_we = 0
- periph_req  out  1  peripheral request, held until ack or timeout
- periph_wr  out  1  peripheral write
- periph_addr  out  32  registered address
- periph_wdata  out  32  registered write data
- periph_be  out  4  registered byte enables
- periph_ack  in  1  peripheral completion pulse; periph_rdata valid in the same cycle for reads
- periph_rdata  in  32  peripheral read data
- bus_err  out  1  one-cycle pulse on a peripheral timeout

Behaviour:
- Decode:
  - mem_cmd_addr[31] = 0 selects RAM (upper bits aliased).
  - mem_cmd_addr[31] = 1 selects peripheral.
  - mem_cmd_instr does not affect decode.
- States: IDLE, RAM_RD, PERIPH, P_RSP.
- Ready and RAM outputs:
  - mem_cmd_ready = 1 in IDLE and RAM_RD; 0 in PERIPH and P_RSP. It is a function of state only, with no path from mem_cmd_valid.
  - RAM outputs are combinational from mem_cmd_*: ram_en = valid && ready && !addr[31]; ram_we = wr ? be : 0.
- IDLE or RAM_RD, command accepted:
  - RAM write: next state IDLE, no response.
  - RAM read: next state RAM_RD.
  - Peripheral: register wr/addr/wdata/be into periph_*, periph_req = 1 from the next cycle, clear the timeout counter, next state PERIPH.
- RAM_RD:
  - mem_rsp_ready = 1 combinationally, mem_rsp_rdata = ram_rdata.
  - A command accepted in the same cycle is handled as above (back-to-back reads at full rate).
  - With no command accepted, next state IDLE.
- PERIPH:
  - periph_req = 1; the counter increments each cycle.
  - periph_ack && read: capture periph_rdata, drop req, go to P_RSP.
  - periph_ack && write: drop req, go to IDLE.
  - counter == PERIPH_TIMEOUT-1 with no ack: drop req, pulse bus_err next cycle. A read goes to P_RSP with data ERR_RDATA; a write goes to IDLE.
  - If ack and timeout coincide, ack wins and there is no bus_err.
- P_RSP: mem_rsp_ready = 1 with the registered data for exactly one cycle, then IDLE.
- Peripheral request latency: periph_req rises 1 cycle after acceptance. A read response comes 1 cycle after ack, or PERIPH_TIMEOUT+1 cycles after acceptance on timeout.
- Outside response cycles, mem_rsp_rdata = 0.
- Reset (synchronous, any state including mid-access): state IDLE; periph_req, periph_wr, bus_err, mem_rsp_ready = 0; counter and registered data/addr/be = 0. An in-flight peripheral access is abandoned with no response, and a late periph_ack is ignored in IDLE.

Test Plan:
- RAM write then read: write addr 0x0000_0010 with be 4'b1111 and data 0x1234_5678, then read the same address → ram_we=4'hf and ram_addr=4 at the write; mem_rsp_ready exactly 1 cycle after the read is accepted, with rdata 0x1234_5678.
- Back-to-back RAM reads: valid held for 4 consecutive reads → mem_cmd_ready stays 1; 4 consecutive mem_rsp_ready pulses, each 1 cycle after its accept.
- Byte write: be 4'b0100 to addr 0x0000_0002 with wdata 0xAABBCCDD → ram_we=4'b0100 and the subsequent read returns only byte 2 changed.
- Peripheral read, 5 wait states: read 0x8000_0004, ack with periph_rdata 0xCAFE_F00D on the 5th periph_req cycle → mem_cmd_ready low throughout; rsp 0xCAFE_F00D 1 cycle after ack; periph_req low after ack.
- Peripheral timeout: read 0x8000_0000 with no ack → req drops after 255 cycles; bus_err 1-cycle pulse; rsp ERR_RDATA 0xDEAD_BEEF. Repeat as a write → bus_err pulse, no rsp, back to IDLE. Repeat with ack arriving exactly on the timeout cycle → normal data, no bus_err.
- Reset mid-access: reset_ low for 1 cycle while in PERIPH → next cycle periph_req=0 and mem_cmd_ready=1; a later stray ack produces no mem_rsp_ready.
